game_session_fsm: RTL and testbench

- Next-generation game controller for the whack-a-mole top: a parametrised multi-round session FSM.
- Sequences IDLE → COUNTDOWN → PLAYING → ROUND_END, repeating for NUM_ROUNDS rounds, then GAME_OVER.
- Adds optional pause, saturating session total, high-score tracking and round indexing.
- Drives the same countdown/game-timer/score/mole-control enables and clears, plus the 7-seg display value.

---
 rtl/game_session_fsm.sv | 239 +++++++++++++++++++++++
 tb/tb_game_session_fsm.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_session_fsm.sv
// game_session_fsm
//   Multi-round session controller for the whack-a-mole game. Walks
//   IDLE -> COUNTDOWN -> PLAYING -> ROUND_END for NUM_ROUNDS rounds, then
//   GAME_OVER, with optional pause, a saturating session total, high-score
//   tracking and a round index. Every output is registered from the
//   next-state decision, so outputs line up with state_out.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   btn_start/pause/clear_score/difficulty_pulse  one-cycle button pulses
//   difficulty_level_input      requested difficulty
//   countdown_sec, game_time_sec  seconds from the countdown / game timers
//   round_score                 current round score counter
//   enable_*/clear_*            submodule enables and clears
//   difficulty_level, round_idx, total_score, high_score, new_high
//   state_out, display_value    state code and 7-seg value
module game_session_fsm #(
  parameter int COUNTDOWN_SEC = 5,
  parameter int GAME_SEC      = 30,
  parameter int TIMER_W       = 6,
  parameter int SCORE_W       = 8,
  parameter int NUM_ROUNDS    = 3,
  parameter int ROUND_W       = 3,
  parameter int GAP_CYC       = 50000000,
  parameter int PAUSE_EN      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_start,
  input  logic               btn_pause,
  input  logic               btn_clear_score,
  input  logic               btn_difficulty_pulse,
  input  logic [1:0]         difficulty_level_input,
  input  logic [TIMER_W-1:0] countdown_sec,
  input  logic [TIMER_W-1:0] game_time_sec,
  input  logic [SCORE_W-1:0] round_score,
  output logic               enable_countdown,
  output logic               enable_game_timer,
  output logic               enable_score,
  output logic               enable_mole_ctrl,
  output logic               clear_countdown,
  output logic               clear_game_timer,
  output logic               clear_score,
  output logic [1:0]         difficulty_level,
  output logic [ROUND_W-1:0] round_idx,
  output logic [SCORE_W-1:0] total_score,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_high,
  output logic [2:0]         state_out,
  output logic [SCORE_W-1:0] display_value
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CD   = 3'd1;
  localparam logic [2:0] S_PLAY = 3'd2;
  localparam logic [2:0] S_PAUS = 3'd3;
  localparam logic [2:0] S_REND = 3'd4;
  localparam logic [2:0] S_OVER = 3'd5;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  logic [2:0]         state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [SCORE_W-1:0] total_q, total_d, high_q, high_d, disp_q, disp_d;
  logic               new_high_q, new_high_d;
  logic [1:0]         diff_q, diff_d;
  logic               en_cd_q, en_cd_d, en_gt_q, en_gt_d, en_sc_q, en_sc_d, en_mc_q, en_mc_d;
  logic               clr_cd_q, clr_cd_d, clr_gt_q, clr_gt_d, clr_sc_q, clr_sc_d;

  logic               restart_s, menu_s, gap_last_s;
  logic [SCORE_W:0]   sum_s;
  logic [SCORE_W-1:0] sat_s;
  logic [TIMER_W-1:0] cd_rem_s;

  assign menu_s     = (state_q == S_IDLE) || (state_q == S_OVER);
  assign gap_last_s = (gap_q == GAP_W'(GAP_CYC - 1));
  assign sum_s      = {1'b0, total_q} + {1'b0, round_score};
  // Session total clamps at all-ones instead of wrapping.
  assign sat_s      = sum_s[SCORE_W] ? {SCORE_W{1'b1}} : sum_s[SCORE_W-1:0];
  assign cd_rem_s   = (countdown_sec >= TIMER_W'(COUNTDOWN_SEC)) ? {TIMER_W{1'b0}}
                    : (TIMER_W'(COUNTDOWN_SEC) - countdown_sec);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gap_q      <= '0;
      round_q    <= '0;
      total_q    <= '0;
      high_q     <= '0;
      disp_q     <= '0;
      new_high_q <= 1'b0;
      diff_q     <= 2'd0;
      en_cd_q    <= 1'b0;
      en_gt_q    <= 1'b0;
      en_sc_q    <= 1'b0;
      en_mc_q    <= 1'b0;
      clr_cd_q   <= 1'b1;
      clr_gt_q   <= 1'b1;
      clr_sc_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      round_q    <= round_d;
      total_q    <= total_d;
      high_q     <= high_d;
      disp_q     <= disp_d;
      new_high_q <= new_high_d;
      diff_q     <= diff_d;
      en_cd_q    <= en_cd_d;
      en_gt_q    <= en_gt_d;
      en_sc_q    <= en_sc_d;
      en_mc_q    <= en_mc_d;
      clr_cd_q   <= clr_cd_d;
      clr_gt_q   <= clr_gt_d;
      clr_sc_q   <= clr_sc_d;
    end
  end

  // Next-state decision; btn_start beats timer expiry, which beats pause.
  always_comb begin
    state_d   = state_q;
    restart_s = 1'b0;
    case (state_q)
      S_IDLE, S_CD, S_PLAY, S_PAUS, S_REND, S_OVER: begin
        if (btn_start) begin
          state_d   = S_CD;
          restart_s = 1'b1;
        end else if (state_q == S_CD) begin
          state_d = (countdown_sec >= TIMER_W'(COUNTDOWN_SEC)) ? S_PLAY : S_CD;
        end else if (state_q == S_PLAY) begin
          if (game_time_sec >= TIMER_W'(GAME_SEC)) state_d = S_REND;
          else if ((PAUSE_EN != 0) && btn_pause) state_d = S_PAUS;
          else state_d = S_PLAY;
        end else if (state_q == S_PAUS) begin
          state_d = ((PAUSE_EN != 0) && btn_pause) ? S_PLAY : S_PAUS;
        end else if (state_q == S_REND) begin
          if (!gap_last_s) state_d = S_REND;
          else if (round_q < ROUND_W'(NUM_ROUNDS - 1)) state_d = S_CD;
          else state_d = S_OVER;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of all registered outputs and session bookkeeping.
  always_comb begin
    en_cd_d  = 1'b0;
    en_gt_d  = 1'b0;
    en_sc_d  = 1'b0;
    en_mc_d  = 1'b0;
    clr_cd_d = 1'b0;
    clr_gt_d = 1'b0;
    clr_sc_d = 1'b0;
    round_d  = round_q;
    total_d  = total_q;
    high_d   = high_q;
    new_high_d = new_high_q;
    diff_d   = diff_q;
    disp_d   = disp_q;
    gap_d    = ((state_q == S_REND) && (state_d == S_REND)) ? gap_q + GAP_W'(1) : '0;

    if (restart_s) begin
      round_d = '0;
      total_d = '0;
    end else if ((state_q == S_PLAY) && (state_d == S_REND)) begin
      total_d = sat_s;
    end else if ((state_q == S_REND) && (state_d == S_CD)) begin
      round_d = round_q + ROUND_W'(1);
    end else if (menu_s && btn_clear_score) begin
      total_d = '0;
    end else begin
      total_d = total_q;
    end

    if (menu_s && btn_clear_score) begin
      high_d     = '0;
      new_high_d = 1'b0;
    end else if ((state_q == S_REND) && (state_d == S_OVER)) begin
      if (total_q > high_q) begin
        high_d     = total_q;
        new_high_d = 1'b1;
      end else begin
        new_high_d = 1'b0;
      end
    end else if (state_d != S_OVER) begin
      new_high_d = 1'b0;
    end else begin
      new_high_d = new_high_q;
    end

    if (menu_s && btn_difficulty_pulse) diff_d = difficulty_level_input;
    else diff_d = diff_q;

    case (state_d)
      S_CD: begin
        en_cd_d  = 1'b1;
        clr_gt_d = 1'b1;
        clr_sc_d = 1'b1;
        // Countdown timer is cleared only on a fresh entry or a restart.
        clr_cd_d = (state_q != S_CD) || restart_s;
        disp_d   = SCORE_W'(cd_rem_s);
      end
      S_PLAY: begin
        en_gt_d = 1'b1;
        en_sc_d = 1'b1;
        en_mc_d = 1'b1;
        disp_d  = round_score;
      end
      S_PAUS: disp_d = round_score;
      S_REND: disp_d = total_d;
      S_OVER: disp_d = total_d;
      default: begin
        clr_cd_d = 1'b1;
        clr_gt_d = 1'b1;
        clr_sc_d = 1'b1;
        disp_d   = high_d;
      end
    endcase
  end

  assign enable_countdown  = en_cd_q;
  assign enable_game_timer = en_gt_q;
  assign enable_score      = en_sc_q;
  assign enable_mole_ctrl  = en_mc_q;
  assign clear_countdown   = clr_cd_q;
  assign clear_game_timer  = clr_gt_q;
  assign clear_score       = clr_sc_q;
  assign difficulty_level  = diff_q;
  assign round_idx         = round_q;
  assign total_score       = total_q;
  assign high_score        = high_q;
  assign new_high          = new_high_q;
  assign state_out         = state_q;
  assign display_value     = disp_q;

endmodule

// File: tb/tb_game_session_fsm.sv
module tb_game_session_fsm;
  localparam int TW = 6;
  localparam int SW = 8;
  localparam int RW = 3;

  localparam int S_STATE = 0, S_ECD = 1, S_EGT = 2, S_ESC = 3, S_EMC = 4, S_CCD = 5,
                 S_CGT = 6, S_CSC = 7, S_DIFF = 8, S_ROUND = 9, S_TOTAL = 10,
                 S_HIGH = 11, S_NEWH = 12, S_DISP = 13, S_BSTATE = 14;

  logic clk = 1'b0;
  logic rst_n, btn_start, btn_pause, btn_clear_score, btn_difficulty_pulse;
  logic [1:0] diff_in;
  logic [TW-1:0] cs, gt;
  logic [SW-1:0] rs;

  logic ecd, egt, esc, emc, ccd, cgt, csc, newh;
  logic [1:0] diff;
  logic [RW-1:0] round;
  logic [SW-1:0] total, high, disp;
  logic [2:0] state;

  logic b_ecd, b_egt, b_esc, b_emc, b_ccd, b_cgt, b_csc, b_newh;
  logic [1:0] b_diff;
  logic [RW-1:0] b_round;
  logic [SW-1:0] b_total, b_high, b_disp;
  logic [2:0] b_state;

  int checks = 0;
  int errors = 0;

  string       tag_q[$];
  int          sel_q[$];
  logic [31:0] val_q[$];

  always #5 clk = ~clk;

  game_session_fsm #(.COUNTDOWN_SEC(3), .GAME_SEC(4), .TIMER_W(TW), .SCORE_W(SW),
                     .NUM_ROUNDS(2), .ROUND_W(RW), .GAP_CYC(4), .PAUSE_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_pause(btn_pause),
    .btn_clear_score(btn_clear_score), .btn_difficulty_pulse(btn_difficulty_pulse),
    .difficulty_level_input(diff_in), .countdown_sec(cs), .game_time_sec(gt),
    .round_score(rs), .enable_countdown(ecd), .enable_game_timer(egt),
    .enable_score(esc), .enable_mole_ctrl(emc), .clear_countdown(ccd),
    .clear_game_timer(cgt), .clear_score(csc), .difficulty_level(diff),
    .round_idx(round), .total_score(total), .high_score(high), .new_high(newh),
    .state_out(state), .display_value(disp));

  game_session_fsm #(.COUNTDOWN_SEC(3), .GAME_SEC(4), .TIMER_W(TW), .SCORE_W(SW),
                     .NUM_ROUNDS(2), .ROUND_W(RW), .GAP_CYC(4), .PAUSE_EN(0)) dut_np (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_pause(btn_pause),
    .btn_clear_score(btn_clear_score), .btn_difficulty_pulse(btn_difficulty_pulse),
    .difficulty_level_input(diff_in), .countdown_sec(cs), .game_time_sec(gt),
    .round_score(rs), .enable_countdown(b_ecd), .enable_game_timer(b_egt),
    .enable_score(b_esc), .enable_mole_ctrl(b_emc), .clear_countdown(b_ccd),
    .clear_game_timer(b_cgt), .clear_score(b_csc), .difficulty_level(b_diff),
    .round_idx(b_round), .total_score(b_total), .high_score(b_high), .new_high(b_newh),
    .state_out(b_state), .display_value(b_disp));

  function automatic logic [31:0] get_obs(input int sel);
    case (sel)
      S_STATE:  get_obs = 32'(state);
      S_ECD:    get_obs = 32'(ecd);
      S_EGT:    get_obs = 32'(egt);
      S_ESC:    get_obs = 32'(esc);
      S_EMC:    get_obs = 32'(emc);
      S_CCD:    get_obs = 32'(ccd);
      S_CGT:    get_obs = 32'(cgt);
      S_CSC:    get_obs = 32'(csc);
      S_DIFF:   get_obs = 32'(diff);
      S_ROUND:  get_obs = 32'(round);
      S_TOTAL:  get_obs = 32'(total);
      S_HIGH:   get_obs = 32'(high);
      S_NEWH:   get_obs = 32'(newh);
      S_DISP:   get_obs = 32'(disp);
      S_BSTATE: get_obs = 32'(b_state);
      default:  get_obs = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic exp(input string tag, input int sel, input int val);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    val_q.push_back(32'(val));
  endtask

  // Advance one clock, then compare everything queued for this edge.
  task automatic step();
    string t;
    int s;
    logic [31:0] e, o;
    @(posedge clk);
    #1;
    while (sel_q.size() > 0) begin
      t = tag_q.pop_front();
      s = sel_q.pop_front();
      e = val_q.pop_front();
      o = get_obs(s);
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", t, o, e);
      end
    end
  endtask

  task automatic exp_reset(input string tag);
    exp({tag, "_state"}, S_STATE, 0);
    exp({tag, "_ecd"}, S_ECD, 0);
    exp({tag, "_egt"}, S_EGT, 0);
    exp({tag, "_esc"}, S_ESC, 0);
    exp({tag, "_emc"}, S_EMC, 0);
    exp({tag, "_ccd"}, S_CCD, 1);
    exp({tag, "_cgt"}, S_CGT, 1);
    exp({tag, "_csc"}, S_CSC, 1);
    exp({tag, "_diff"}, S_DIFF, 0);
    exp({tag, "_round"}, S_ROUND, 0);
    exp({tag, "_total"}, S_TOTAL, 0);
    exp({tag, "_high"}, S_HIGH, 0);
    exp({tag, "_newh"}, S_NEWH, 0);
    exp({tag, "_disp"}, S_DISP, 0);
  endtask

  task automatic enter_play();
    cs = 6'd3;
    exp("play_state", S_STATE, 2);
    exp("play_emc", S_EMC, 1);
    exp("play_egt", S_EGT, 1);
    exp("play_cgt", S_CGT, 0);
    step();
    cs = 6'd0;
  endtask

  task automatic end_round(input int score, input int tot);
    rs = SW'(score);
    gt = 6'd4;
    exp("rend_state", S_STATE, 4);
    exp("rend_total", S_TOTAL, tot);
    exp("rend_disp", S_DISP, tot);
    exp("rend_emc", S_EMC, 0);
    step();
    gt = 6'd0;
  endtask

  task automatic gap_wait(input int nxt, input int rnd, input int hi, input int nh);
    for (int i = 0; i < 3; i++) begin
      exp("gap_hold", S_STATE, 4);
      step();
    end
    exp("gap_next", S_STATE, nxt);
    exp("gap_round", S_ROUND, rnd);
    exp("gap_high", S_HIGH, hi);
    exp("gap_newh", S_NEWH, nh);
    step();
  endtask

  initial begin
    rst_n = 1'b0; btn_start = 1'b0; btn_pause = 1'b0; btn_clear_score = 1'b0;
    btn_difficulty_pulse = 1'b0; diff_in = 2'd0; cs = 6'd0; gt = 6'd0; rs = 8'd0;
    exp_reset("rst");
    step();
    rst_n = 1'b1;
    exp("idle_state", S_STATE, 0);
    exp("idle_ccd", S_CCD, 1);
    exp("idle_disp", S_DISP, 0);
    step();

    // Countdown entry and display
    btn_start = 1'b1;
    exp("cd_state", S_STATE, 1);
    exp("cd_ccd_entry", S_CCD, 1);
    exp("cd_ecd", S_ECD, 1);
    exp("cd_disp3", S_DISP, 3);
    step();
    btn_start = 1'b0;
    exp("cd_ccd_once", S_CCD, 0);
    exp("cd_cgt", S_CGT, 1);
    exp("cd_disp3b", S_DISP, 3);
    step();
    cs = 6'd1; exp("cd_disp2", S_DISP, 2); step();
    cs = 6'd2; exp("cd_disp1", S_DISP, 1); step();
    enter_play();

    // Session 1: 10 + 25 = 35, new high
    end_round(10, 10);
    gap_wait(1, 1, 0, 0);
    enter_play();
    end_round(25, 35);
    gap_wait(5, 1, 35, 1);

    // Session 2: 10 + 10 = 20, high stays
    btn_start = 1'b1;
    exp("s2_state", S_STATE, 1);
    exp("s2_round", S_ROUND, 0);
    exp("s2_total", S_TOTAL, 0);
    exp("s2_newh", S_NEWH, 0);
    exp("s2_ccd", S_CCD, 1);
    step();
    btn_start = 1'b0;
    enter_play();
    end_round(10, 10);
    gap_wait(1, 1, 35, 0);
    enter_play();
    end_round(10, 20);
    gap_wait(5, 1, 35, 0);

    btn_clear_score = 1'b1;
    exp("clr_high", S_HIGH, 0);
    exp("clr_total", S_TOTAL, 0);
    exp("clr_newh", S_NEWH, 0);
    exp("clr_disp", S_DISP, 0);
    exp("clr_state", S_STATE, 5);
    step();
    btn_clear_score = 1'b0;

    // Pause / resume, and no pause when disabled
    btn_start = 1'b1; exp("p_start", S_STATE, 1); step(); btn_start = 1'b0;
    enter_play();
    btn_pause = 1'b1;
    exp("pause_state", S_STATE, 3);
    exp("pause_egt", S_EGT, 0);
    exp("pause_esc", S_ESC, 0);
    exp("pause_emc", S_EMC, 0);
    exp("pause_disp", S_DISP, 10);
    exp("nopause_state", S_BSTATE, 2);
    step();
    exp("resume_state", S_STATE, 2);
    exp("resume_egt", S_EGT, 1);
    exp("nopause_state2", S_BSTATE, 2);
    step();
    btn_pause = 1'b0;

    // Priority: start beats expiry; expiry beats pause
    end_round(7, 7);
    gap_wait(1, 1, 0, 0);
    enter_play();
    btn_start = 1'b1; gt = 6'd4;
    exp("prio_state", S_STATE, 1);
    exp("prio_round", S_ROUND, 0);
    exp("prio_total", S_TOTAL, 0);
    exp("prio_ccd", S_CCD, 1);
    step();
    btn_start = 1'b0; gt = 6'd0;
    enter_play();
    rs = 8'd5; gt = 6'd4; btn_pause = 1'b1;
    exp("prio2_state", S_STATE, 4);
    exp("prio2_total", S_TOTAL, 5);
    exp("prio2_bstate", S_BSTATE, 4);
    step();
    gt = 6'd0; btn_pause = 1'b0;

    // Restart from ROUND_END, then saturation 200 + 100
    btn_start = 1'b1;
    exp("re_start_state", S_STATE, 1);
    exp("re_start_total", S_TOTAL, 0);
    step();
    btn_start = 1'b0;
    enter_play();
    end_round(200, 200);
    gap_wait(1, 1, 0, 0);
    enter_play();
    end_round(100, 255);

    // Difficulty ignored while playing, reset mid-play, then latch in IDLE
    btn_start = 1'b1; exp("d_start", S_STATE, 1); step(); btn_start = 1'b0;
    enter_play();
    btn_difficulty_pulse = 1'b1; diff_in = 2'd2;
    exp("diff_play", S_DIFF, 0);
    exp("diff_play_state", S_STATE, 2);
    step();
    btn_difficulty_pulse = 1'b0;
    rst_n = 1'b0;
    exp_reset("midrst");
    step();
    rst_n = 1'b1;
    btn_difficulty_pulse = 1'b1;
    exp("diff_idle", S_DIFF, 2);
    exp("diff_idle_state", S_STATE, 0);
    step();
    btn_difficulty_pulse = 1'b0;
    exp("diff_hold", S_DIFF, 2);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
